// File: rtl/fp_mul_pkg.sv
// Shared types, widths and IEEE-754 single-precision field helpers for the
// iterative Booth multiplier controller.
package fp_mul_pkg;

    localparam int EXP_W   = 8;
    localparam int MANT_W  = 23;
    localparam int BIAS    = 127;
    localparam int ITERS   = MANT_W + 2;
    localparam int BOOTH_W = MANT_W + 2;      // sign guard + hidden bit + fraction
    localparam int P_W     = 2 * BOOTH_W + 1; // accumulator, multiplier, Booth guard bit
    localparam int EXPS_W  = EXP_W + 2;       // signed exponent with overflow headroom
    localparam int CNT_W   = $clog2(ITERS);

    localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        NORM,
        DONE
    } state_t;

    function automatic logic f_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [MANT_W-1:0] f_frac(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage

// File: rtl/booth_r2_step.sv
// One combinational radix-2 Booth step: add/subtract the multiplicand into the
// upper accumulator according to P[1:0], then arithmetic shift right by one.
module booth_r2_step
    import fp_mul_pkg::*;
(
    input  logic [P_W-1:0]     p,
    input  logic [BOOTH_W-1:0] mb,
    output logic [P_W-1:0]     p_next
);

    logic [BOOTH_W-1:0] hi;

    always_comb begin
        hi = p[P_W-1:P_W-BOOTH_W];
        case (p[1:0])
            2'b01:   hi = hi + mb;
            2'b10:   hi = hi - mb;
            default: hi = p[P_W-1:P_W-BOOTH_W];
        endcase
        p_next = {hi[BOOTH_W-1], hi, p[P_W-BOOTH_W-1:1]};
    end

endmodule

// File: rtl/fp_mul_booth_ctrl.sv
// Iterative single-precision multiplier: unpack, 25 Booth steps on a shared
// datapath, normalise by one position, then pack with exception flagging.
module fp_mul_booth_ctrl
    import fp_mul_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        exception,
    output logic        busy
);

    localparam logic signed [EXPS_W-1:0] EXP_MIN_BAD = '0;
    localparam logic signed [EXPS_W-1:0] EXP_MAX_BAD = EXPS_W'(255);

    state_t                     state;
    logic [31:0]                a_r, b_r;
    logic                       sign_r, exc_in_r, zero_r;
    logic signed [EXPS_W-1:0]   exp_sum_r, norm_exp_r;
    logic [MANT_W-1:0]          norm_frac_r;
    logic [BOOTH_W-1:0]         mb_r;
    logic [P_W-1:0]             p_r, p_next;
    logic [CNT_W-1:0]           cnt_r;
    logic [2*BOOTH_W-3:0]       prod;
    logic [EXP_W-1:0]           ea, eb;
    logic [MANT_W-1:0]          fa, fb;

    assign ea   = f_exp(a_r);
    assign eb   = f_exp(b_r);
    assign fa   = f_frac(a_r);
    assign fb   = f_frac(b_r);
    // Product magnitude of two 24-bit significands never exceeds 48 bits.
    assign prod = p_r[2*BOOTH_W-2:1];

    booth_r2_step u_step (
        .p      (p_r),
        .mb     (mb_r),
        .p_next (p_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            sign_r      <= 1'b0;
            exc_in_r    <= 1'b0;
            zero_r      <= 1'b0;
            exp_sum_r   <= '0;
            norm_exp_r  <= '0;
            norm_frac_r <= '0;
            mb_r        <= '0;
            p_r         <= '0;
            cnt_r       <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            result      <= '0;
            exception   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= b;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= PREP;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                PREP: begin
                    sign_r    <= f_sign(a_r) ^ f_sign(b_r);
                    exp_sum_r <= $signed({2'b00, ea} + {2'b00, eb} - EXPS_W'(BIAS));
                    mb_r      <= {1'b0, |eb, fb};
                    p_r       <= {{BOOTH_W{1'b0}}, 1'b0, |ea, fa, 1'b0};
                    cnt_r     <= '0;
                    exc_in_r  <= (ea == EXP_ALL_ONES) || (eb == EXP_ALL_ONES) ||
                                 ((ea == '0) && (fa != '0)) || ((eb == '0) && (fb != '0));
                    zero_r    <= ((ea == '0) && (fa == '0)) || ((eb == '0) && (fb == '0));
                    state     <= ITER;
                end
                ITER: begin
                    p_r   <= p_next;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(ITERS - 1))
                        state <= NORM;
                end
                NORM: begin
                    if (prod[47]) begin
                        norm_frac_r <= prod[46:24];
                        norm_exp_r  <= exp_sum_r + EXPS_W'(1);
                    end else begin
                        norm_frac_r <= prod[45:23];
                        norm_exp_r  <= exp_sum_r;
                    end
                    state <= DONE;
                end
                DONE: begin
                    // First DONE cycle packs; afterwards hold until the consumer takes it.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        if (exc_in_r) begin
                            exception <= 1'b1;
                            result    <= '0;
                        end else if (zero_r) begin
                            exception <= 1'b0;
                            result    <= {sign_r, 31'b0};
                        end else if (norm_exp_r <= EXP_MIN_BAD || norm_exp_r >= EXP_MAX_BAD) begin
                            exception <= 1'b1;
                            result    <= '0;
                        end else begin
                            exception <= 1'b0;
                            result    <= {sign_r, norm_exp_r[EXP_W-1:0], norm_frac_r};
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_booth_ctrl.sv
// Directed bench for fp_mul_booth_ctrl: a driver issues operand pairs and
// queues hand-computed results; a monitor pops and compares on output.
module tb_fp_mul_booth_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        exception;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [32:0] exp_q[$];
    int          lat_q[$];
    logic        ov_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_mul_booth_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .exception (exception),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v,
                            input logic [31:0] er, input logic ee);
        int w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready %b expected 1", in_ready);
            return;
        end
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        exp_q.push_back({ee, er});
        lat_q.push_back(cyc + 1);
        tick();
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
    endtask

    task automatic finish_op(input int bp);
        int w = 0;
        out_ready = (bp == 0);
        while (!out_valid && w < 60) begin
            tick();
            w++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL result_timeout: out_valid %b expected 1", out_valid);
            exp_q.delete();
            lat_q.delete();
            return;
        end
        for (int i = 0; i < bp; i++) begin
            check("in_ready_stall", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("in_ready_after", 32'(in_ready), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [31:0] er, input logic ee, input int bp);
        start_op(ta, tb_v, er, ee);
        finish_op(bp);
    endtask

    // Monitor: latency on the rising edge of out_valid, value on every valid cycle.
    initial begin : monitor
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (out_valid && !ov_prev) begin
                if (lat_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: out_valid=1 with nothing pending, result %h", result);
                end else begin
                    check("latency", 32'(cyc - lat_q.pop_front()), 32'd28);
                end
            end
            if (out_valid && exp_q.size() != 0) begin
                e = exp_q[0];
                check(out_ready ? "result" : "hold_result", result, e[31:0]);
                check(out_ready ? "exception" : "hold_exception", 32'(exception), 32'(e[32]));
                if (out_ready)
                    e = exp_q.pop_front();
            end
            ov_prev = out_valid;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        repeat (2) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_exception", 32'(exception), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();
        check("in_ready_release", 32'(in_ready), 32'd1);

        run_op(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 0);  // 1.5 * 2.0
        run_op(32'hBFC00000, 32'h3FC00000, 32'hC0100000, 1'b0, 0);  // -1.5 * 1.5
        run_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 0);  // 1.0 * 1.0
        run_op(32'h7F800000, 32'h3F800000, 32'h00000000, 1'b1, 0);  // inf operand
        run_op(32'h00800000, 32'h00800000, 32'h00000000, 1'b1, 0);  // underflow
        run_op(32'h00000001, 32'h3F800000, 32'h00000000, 1'b1, 0);  // denormal operand
        run_op(32'h00000000, 32'hBF800000, 32'h80000000, 1'b0, 0);  // signed zero
        run_op(32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 5);  // backpressure

        // Abort in the middle of the Booth iterations.
        start_op(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0);
        repeat (11) tick();
        reset = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_exception", 32'(exception), 32'd0);
        exp_q.delete();
        lat_q.delete();
        repeat (3) tick();
        check("abort_hold_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        tick();
        check("abort_release_in_ready", 32'(in_ready), 32'd1);
        run_op(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 0);

        repeat (5) tick();
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
